// File: rtl/dmem_arbiter.sv
// Two-port (cpu / dbg) sequencer for the single-port data_mem: round-robin grant,
// one access at a time, registered read capture and address range checking.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no access in progress, requests sampled here
//   ACCESS  | mem_* drive the granted command
//   CAPTURE | read data returning from data_mem
//   DONE    | ack/err high for the winning port
module dmem_arbiter #(
    parameter int DEPTH  = 32,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [WORD_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [WORD_W-1:0] dbg_addr,
    input  logic [WORD_W-1:0] dbg_wdata,
    output logic [WORD_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic              dbg_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_DONE} state_t;

    localparam logic              PORT_CPU = 1'b0;
    localparam logic              PORT_DBG = 1'b1;
    localparam logic [WORD_W:0]   ADDR_LIM = (WORD_W+1)'(DEPTH);

    state_t            state;
    logic              last_grant;
    logic              cmd_port;
    logic              cmd_we;
    logic              err_pending;

    logic              grant_dbg;
    logic              sel_we;
    logic [WORD_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_wdata;
    logic              sel_err;

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign dbg_stall = dbg_req & ~dbg_ack;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_dbg = dbg_req;
        if (cpu_req && dbg_req) begin
            grant_dbg = (last_grant == PORT_CPU);
        end
        sel_we    = grant_dbg ? dbg_we    : cpu_we;
        sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
        sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
        sel_err   = ({1'b0, sel_addr} >= ADDR_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            last_grant  <= PORT_DBG;
            cmd_port    <= PORT_CPU;
            cmd_we      <= 1'b0;
            err_pending <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_rdata   <= '0;
            dbg_ack     <= 1'b0;
            dbg_err     <= 1'b0;
            dbg_rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req || dbg_req) begin
                        cmd_port    <= grant_dbg;
                        last_grant  <= grant_dbg;
                        cmd_we      <= sel_we;
                        mem_addr    <= sel_addr;
                        mem_wdata   <= sel_wdata;
                        err_pending <= sel_err;
                        mem_write   <= sel_we & ~sel_err;
                        mem_read    <= ~sel_we & ~sel_err;
                        state       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (!cmd_we && !err_pending) begin
                        state <= S_CAPTURE;
                    end else begin
                        state <= S_DONE;
                        if (cmd_port == PORT_DBG) begin
                            dbg_ack <= 1'b1;
                            dbg_err <= err_pending;
                            if (!cmd_we) dbg_rdata <= '0;
                        end else begin
                            cpu_ack <= 1'b1;
                            cpu_err <= err_pending;
                            if (!cmd_we) cpu_rdata <= '0;
                        end
                    end
                end
                S_CAPTURE: begin
                    state <= S_DONE;
                    if (cmd_port == PORT_DBG) begin
                        dbg_rdata <= mem_rdata;
                        dbg_ack   <= 1'b1;
                        dbg_err   <= err_pending;
                    end else begin
                        cpu_rdata <= mem_rdata;
                        cpu_ack   <= 1'b1;
                        cpu_err   <= err_pending;
                    end
                end
                S_DONE: begin
                    cpu_ack <= 1'b0;
                    cpu_err <= 1'b0;
                    dbg_ack <= 1'b0;
                    dbg_err <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencing controller and two-port arbiter for the single-port data memory (`data_mem`). It shares the memory between the pipeline MEM stage (cpu port) and the debug/loader port (dbg port). It issues one memory access at a time, captures registered read data, range-checks addresses, and raises a stall to the pipeline while the cpu request is outstanding. It sits between the MEM-stage logic and `data_mem`, with `read_clk` and `write_clk` of `data_mem` both tied to `clk`.

## Interface
- DEPTH, 32: number of memory words; valid addresses are 0..DEPTH-1.
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  cpu access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  `WORD  word address.
- cpu_wdata  in  `WORD  write data.
- cpu_rdata  out  `WORD  read result; valid while cpu_ack is high, held until the next cpu read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  high with cpu_ack if the address was out of range.
- cpu_stall  out  1  equals cpu_req & ~cpu_ack (combinational).
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack, dbg_err: identical semantics for the debug port.
- mem_read  out  1  to `data_mem`.
- mem_write  out  1  to `data_mem`.
- mem_addr  out  `WORD  to `data_mem`.
- mem_wdata  out  `WORD  to `data_mem`.
- mem_rdata  in  `WORD  from `data_mem`; registered, valid on the cycle after the mem_read edge; Z otherwise.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: mem_* drive the granted command.
  - CAPTURE: read data return.
  - DONE: ack/err high for the winner.
- IDLE transitions:
  - If any req is high: arbitrate, latch winner id, we, addr and wdata into command registers, go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration is round-robin on a last_grant bit.
  - Only one port requesting: that port wins.
  - Both ports requesting: the port not equal to last_grant wins.
  - last_grant updates on every grant.
  - Reset value of last_grant is dbg, so the cpu wins the first tie.
- Range check: addr >= DEPTH sets err_pending.
  - mem_read and mem_write stay 0 for the whole transaction.
  - The transaction still walks ACCESS -> DONE, so timing is address-independent for writes.
- ACCESS:
  - mem_write = we & ~err_pending; mem_read = ~we & ~err_pending.
  - mem_addr and mem_wdata come from the command registers.
  - Next state is CAPTURE for in-range reads, otherwise DONE.
- CAPTURE:
  - mem_read and mem_write are 0.
  - At the edge leaving CAPTURE, load mem_rdata into the winner's rdata register.
  - Go to DONE.
- DONE:
  - Winner's ack = 1; winner's err = err_pending.
  - For an erroring read, the winner's rdata is 0.
  - Go to IDLE.
- Requests are sampled only in IDLE. The loser's req stays pending and is served next.
- Non-winner rdata registers are never modified.
- Requester contract: drop req at the edge ending its ack cycle. A req still high in IDLE is a new request.
- Changes of addr, we or wdata after the grant edge are ignored (latched).

## Timing
- Reset values:
  - state = IDLE, last_grant = dbg.
  - mem_read = mem_write = 0; mem_addr = mem_wdata = 0.
  - cpu_ack = dbg_ack = 0; cpu_err = dbg_err = 0.
  - cpu_rdata = dbg_rdata = 0.
  - cpu_stall follows cpu_req.
- All outputs except cpu_stall and dbg_stall are registered.
- Write, req sampled at edge E0:
  - mem_write is high in cycle E0–E1.
  - Memory writes at E1.
  - ack is high in cycle E1–E2.
- Read:
  - mem_read is high in cycle E0–E1.
  - mem_rdata is valid in cycle E1–E2 and captured at E2.
  - ack and rdata are valid in cycle E2–E3.
- Out-of-range access: ack in cycle E1–E2 for both reads and writes.
- Back-to-back throughput: one write per 3 cycles, one read per 4 cycles (IDLE cycle included).
- Reset asserted in any state:
  - At that edge, return to IDLE with reset values.
  - The in-flight access is abandoned and no ack is issued.
  - A write already issued at that same edge still completes in `data_mem`.

## Test plan
- Reset, then cpu write addr 3, data 0xA5 -> mem_write high exactly 1 cycle with mem_addr = 3; cpu_ack in cycle E1–E2; cpu_stall high for 2 cycles.
- cpu read addr 3 after the above -> mem_read 1 cycle; cpu_rdata = 0xA5 with cpu_ack 3 cycles after the req edge; dbg_rdata unchanged (0).
- cpu_req and dbg_req raised on the same edge, both reads (addr 1, addr 2), both re-requesting after ack for 4 rounds -> grants alternate cpu, dbg, cpu, dbg…; neither port is starved.
- dbg write addr 40 (DEPTH = 32) -> mem_write never asserted; dbg_ack and dbg_err high together 2 cycles after the req edge; memory contents unchanged.
- Reset asserted during CAPTURE of a cpu read -> next cycle state IDLE, no cpu_ack, cpu_rdata = 0. The held request is re-served normally after reset deasserts.
- Port changes cpu_addr from 5 to 6 one cycle after the grant edge -> mem_addr stays 5.
